lfsr_misr_bist: RTL and testbench
=================================

Name: lfsr_misr_bist

Overview:
Parametrised built-in self-test engine for sequential benchmark cores. It drives pseudo-random stimulus into a core under test from a Galois LFSR and compacts the core's responses into a Galois MISR. It then compares the final signature against a golden value. It sits between the test-access controller and one core, which is fed from PAT and returns RESP.

Parameters:
WIDTH, 16, width of stimulus, response and signature.
POLY, 16'hB400, Galois feedback mask shared by LFSR and MISR; bit WIDTH-1 must be set.
SEED, 16'h0001, LFSR initial state; must be nonzero.
PATTERNS, 256, number of patterns per session; range 2..2^WIDTH-1.

Ports:
CK  in  1  clock, rising edge.
RN  in  1  asynchronous active-low reset.
START  in  1  level; sampled high in IDLE or DONE to begin a session.
ABORT  in  1  synchronous abort; has priority over START.
RESP  in  WIDTH  core response, one cycle after the corresponding PAT.
GOLDEN  in  WIDTH  expected signature; sampled on the DRAIN->DONE edge.
PAT  out  WIDTH  current pattern (LFSR state).
BUSY  out  1  high in RUN and DRAIN.
DONE  out  1  high in DONE.
SIG  out  WIDTH  MISR state; final signature when DONE=1.
PASS  out  1  registered (SIG==GOLDEN), valid only while DONE=1.

Behaviour:
- Reset (RN low, asynchronous):
  - state=IDLE, PAT=SEED, SIG=0, count=0.
  - BUSY=0, DONE=0, PASS=0.
- Shift operator: sh(x) = (x>>1) ^ (x[0] ? POLY : 0).
  - LFSR step: PAT <= sh(PAT).
  - MISR step: SIG <= sh(SIG) ^ RESP.
- IDLE:
  - PAT=SEED, SIG=0, count=0 held.
  - START=1 -> RUN on the next edge.
- RUN:
  - On every edge: PAT steps and count increments.
  - SIG steps only when count>=1. The compacted RESP belongs to pattern count-1.
  - On the edge where count==PATTERNS-1 -> DRAIN; PAT holds from that edge onward.
- DRAIN (one cycle):
  - SIG steps once to compact the last pattern's response.
  - -> DONE; PASS <= (sh(SIG)^RESP)==GOLDEN on the same edge.
- Session timing:
  - BUSY is high for exactly PATTERNS+1 cycles.
  - Exactly PATTERNS responses are compacted.
- DONE:
  - DONE=1; SIG and PASS hold.
  - START=1 -> reinitialise (PAT=SEED, SIG=0, count=0) and enter RUN on the same edge.
  - START=0 -> stay in DONE.
- ABORT=1 in any state:
  - Next edge goes to IDLE with IDLE values; DONE=0, PASS=0.
  - ABORT wins over a simultaneous START.
- START held high:
  - From IDLE this yields one session.
  - DONE lasts one cycle, then a new session begins (back-to-back sessions).
- Illegal parameters (SEED==0, POLY[WIDTH-1]==0, PATTERNS out of range): elaboration-time error; no runtime lockup handling.
- RN asserted mid-session: immediate return to reset values; no partial signature retained.

Test Plan:
- WIDTH=4, POLY=4'hC, SEED=1, PATTERNS=15, START pulse -> PAT sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2; BUSY high 16 cycles; DONE follows.
- Same config, PATTERNS=4, RESP=~PAT delayed one cycle (E,3,9,C), GOLDEN=5 -> SIG=5, PASS=1, DONE=1.
- Same as previous with GOLDEN=6 -> SIG=5, PASS=0.
- RESP tied 0, any PATTERNS, GOLDEN=0 -> SIG=0, PASS=1.
- ABORT asserted on 3rd RUN cycle with START=1 -> next cycle IDLE, PAT=1, SIG=0, BUSY=0, DONE=0.
- RN pulsed low asynchronously mid-RUN, then START held high -> outputs reset immediately; two consecutive sessions give identical SIG, DONE high 1 cycle between them.

Source files
------------

// File: rtl/lfsr_misr_bist.sv
// BIST engine: a Galois LFSR drives stimulus into one core, a Galois MISR compacts
// its responses, and the final signature is compared against a golden value.
module lfsr_misr_bist #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] POLY     = 16'hB400,
   parameter logic [WIDTH-1:0] SEED     = 16'h0001,
   parameter int               PATTERNS = 256
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             START,
   input  logic             ABORT,
   input  logic [WIDTH-1:0] RESP,
   input  logic [WIDTH-1:0] GOLDEN,
   output logic [WIDTH-1:0] PAT,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SIG,
   output logic             PASS
);

   generate
      if (SEED == '0) begin : g_bad_seed
         $error("lfsr_misr_bist: SEED must be nonzero");
      end
      if (POLY[WIDTH-1] == 1'b0) begin : g_bad_poly
         $error("lfsr_misr_bist: POLY must have its top bit set");
      end
      if (PATTERNS < 2 || longint'(PATTERNS) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_count
         $error("lfsr_misr_bist: PATTERNS out of range");
      end
   endgenerate

   localparam logic [WIDTH-1:0] LAST = WIDTH'(PATTERNS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] misr_nxt;

   // Galois right shift shared by the pattern generator and the compactor
   function automatic logic [WIDTH-1:0] sh(input logic [WIDTH-1:0] x);
      return (x >> 1) ^ (x[0] ? POLY : '0);
   endfunction

   assign misr_nxt = sh(sig_q) ^ RESP;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      if (ABORT) begin
         state_d = S_IDLE;
         pat_d   = SEED;
         sig_d   = '0;
         cnt_d   = '0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               pat_d  = SEED;
               sig_d  = '0;
               cnt_d  = '0;
               pass_d = 1'b0;
               if (START) state_d = S_RUN;
            end
            S_RUN: begin
               // response seen on count N belongs to pattern N-1, so skip count 0
               if (cnt_q != '0) sig_d = misr_nxt;
               if (cnt_q == LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  pat_d = sh(pat_q);
                  cnt_d = cnt_q + WIDTH'(1);
               end
            end
            S_DRAIN: begin
               sig_d   = misr_nxt;
               pass_d  = (misr_nxt == GOLDEN);
               state_d = S_DONE;
            end
            S_DONE: begin
               if (START) begin
                  state_d = S_RUN;
                  pat_d   = SEED;
                  sig_d   = '0;
                  cnt_d   = '0;
                  pass_d  = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
               pat_d   = SEED;
               sig_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= S_IDLE;
         pat_q   <= SEED;
         sig_q   <= '0;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   assign PAT  = pat_q;
   assign SIG  = sig_q;
   assign BUSY = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign DONE = (state_q == S_DONE);
   assign PASS = pass_q;

endmodule

// File: tb/tb_lfsr_misr_bist.sv
// Bench for lfsr_misr_bist: two 4-bit instances (15 and 4 patterns) checked every
// cycle against a session-position model, plus literal checks from worked examples.
`timescale 1ns/1ps
module tb_lfsr_misr_bist;
   localparam int         W    = 4;
   localparam logic [3:0] POLY = 4'hC;
   localparam logic [3:0] SEED = 4'h1;
   localparam int         PA   = 15;
   localparam int         PB   = 4;

   logic       CK = 1'b0;
   logic       RN = 1'b0;
   logic [1:0] start = '0;
   logic [1:0] abort = '0;
   logic [W-1:0] resp [2];
   logic [W-1:0] golden [2];
   logic [W-1:0] pat [2];
   logic [W-1:0] sig [2];
   logic [1:0] busy, done, pass;

   always #5 CK = ~CK;

   lfsr_misr_bist #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .PATTERNS(PA)) dut_a (
      .CK(CK), .RN(RN), .START(start[0]), .ABORT(abort[0]), .RESP(resp[0]),
      .GOLDEN(golden[0]), .PAT(pat[0]), .BUSY(busy[0]), .DONE(done[0]),
      .SIG(sig[0]), .PASS(pass[0]));

   lfsr_misr_bist #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .PATTERNS(PB)) dut_b (
      .CK(CK), .RN(RN), .START(start[1]), .ABORT(abort[1]), .RESP(resp[1]),
      .GOLDEN(golden[1]), .PAT(pat[1]), .BUSY(busy[1]), .DONE(done[1]),
      .SIG(sig[1]), .PASS(pass[1]));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int plen(input int i);
      return (i == 0) ? PA : PB;
   endfunction

   function automatic logic [W-1:0] shf(input logic [W-1:0] x);
      return (x / 2) ^ (((x % 2) == 1) ? POLY : 4'h0);
   endfunction

   // Model: m_pos = -1 idle, 0..P-1 pattern slots, P drain slot, P+1 finished
   logic [W-1:0] seq [16];
   int           m_pos [2] = '{-1, -1};
   logic [W-1:0] m_acc [2] = '{4'h0, 4'h0};
   logic         m_pass [2] = '{1'b0, 1'b0};

   always @(posedge CK or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_acc[i] = '0; m_pass[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (abort[i]) begin
               m_pos[i] = -1; m_acc[i] = '0; m_pass[i] = 1'b0;
            end else if (m_pos[i] == -1 || m_pos[i] == plen(i) + 1) begin
               if (start[i]) begin
                  m_pos[i] = 0; m_acc[i] = '0; m_pass[i] = 1'b0;
               end
            end else begin
               if (m_pos[i] >= 1) m_acc[i] = shf(m_acc[i]) ^ resp[i];
               if (m_pos[i] == plen(i)) begin
                  m_pass[i] = (m_acc[i] == golden[i]);
                  m_pos[i]  = plen(i) + 1;
               end else begin
                  m_pos[i]++;
               end
            end
         end
      end
   end

   logic         chk_en = 1'b0;
   logic         rec_pat = 1'b0;
   logic         rec_done = 1'b0;
   logic [W-1:0] pat_q [$];
   logic [W-1:0] done_q [$];
   int           busy_len [2] = '{0, 0};
   logic [W-1:0] last_pat [2];

   always @(negedge CK) begin
      last_pat[0] <= pat[0];
      last_pat[1] <= pat[1];
   end

   always @(negedge CK) begin
      if (RN && chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int p;
            p = plen(i);
            if (m_pos[i] < 0) begin
               check("idle_pat", 32'(pat[i]), 32'(SEED));
               check("idle_sig", 32'(sig[i]), 0);
               check("idle_busy", 32'(busy[i]), 0);
               check("idle_done", 32'(done[i]), 0);
               check("idle_pass", 32'(pass[i]), 0);
            end else if (m_pos[i] <= p) begin
               check("run_pat", 32'(pat[i]), 32'(seq[(m_pos[i] < p) ? m_pos[i] : p - 1]));
               check("run_sig", 32'(sig[i]), 32'(m_acc[i]));
               check("run_busy", 32'(busy[i]), 1);
               check("run_done", 32'(done[i]), 0);
            end else begin
               check("done_pat", 32'(pat[i]), 32'(seq[p - 1]));
               check("done_sig", 32'(sig[i]), 32'(m_acc[i]));
               check("done_busy", 32'(busy[i]), 0);
               check("done_done", 32'(done[i]), 1);
               check("done_pass", 32'(pass[i]), 32'(m_pass[i]));
            end
            if (busy[i]) begin
               busy_len[i]++;
            end else begin
               if (busy_len[i] > 0 && done[i]) check("busy_cycles", busy_len[i], p + 1);
               busy_len[i] = 0;
            end
         end
         if (rec_pat && busy[0]) pat_q.push_back(pat[0]);
         if (rec_done && done[0]) done_q.push_back(sig[0]);
      end
   end

   // resp mode per instance: 0 random, 1 inverted previous pattern, 2 tied zero
   int mode [2] = '{0, 0};

   task automatic cyc();
      @(posedge CK);
      #1;
      for (int i = 0; i < 2; i++) begin
         case (mode[i])
            1:       resp[i] = ~last_pat[i];
            2:       resp[i] = '0;
            default: resp[i] = W'($urandom);
         endcase
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < 2; i++) begin
         check({tag, "_pat"}, 32'(pat[i]), 32'h1);
         check({tag, "_sig"}, 32'(sig[i]), 0);
         check({tag, "_busy"}, 32'(busy[i]), 0);
         check({tag, "_done"}, 32'(done[i]), 0);
         check({tag, "_pass"}, 32'(pass[i]), 0);
      end
   endtask

   logic [W-1:0] lit [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                              4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

   initial begin
      resp[0] = '0; resp[1] = '0; golden[0] = '0; golden[1] = '0;
      seq[0] = SEED;
      for (int k = 1; k < 16; k++) seq[k] = shf(seq[k-1]);
      for (int k = 0; k < 15; k++) check("model_seq", 32'(seq[k]), 32'(lit[k]));

      @(posedge CK);
      #2;
      check_reset_vals("reset");
      #5;
      RN = 1'b1;
      chk_en = 1'b1;
      cyc();

      // full 15-pattern run on A (random responses); worked 4-pattern example on B
      mode[0] = 0; mode[1] = 1;
      golden[0] = W'($urandom); golden[1] = 4'h5;
      rec_pat = 1'b1;
      start = 2'b11;
      cyc();
      start = 2'b00;
      repeat (20) cyc();
      rec_pat = 1'b0;
      check("pat_count", pat_q.size(), 16);
      for (int k = 0; k < 15 && k < pat_q.size(); k++) check("pat_seq", 32'(pat_q[k]), 32'(lit[k]));
      if (pat_q.size() == 16) check("pat_hold", 32'(pat_q[15]), 32'h2);
      check("ex_sig", 32'(sig[1]), 32'h5);
      check("ex_pass", 32'(pass[1]), 1);
      check("ex_done", 32'(done[1]), 1);

      // same example with a wrong golden value
      golden[1] = 4'h6;
      start[1] = 1'b1;
      cyc();
      start[1] = 1'b0;
      repeat (8) cyc();
      check("exbad_sig", 32'(sig[1]), 32'h5);
      check("exbad_pass", 32'(pass[1]), 0);

      // responses tied low compact to zero
      mode[0] = 2; mode[1] = 2;
      golden[0] = '0; golden[1] = '0;
      start = 2'b11;
      cyc();
      start = 2'b00;
      repeat (20) cyc();
      check("zero_sig_a", 32'(sig[0]), 0);
      check("zero_pass_a", 32'(pass[0]), 1);
      check("zero_sig_b", 32'(sig[1]), 0);
      check("zero_pass_b", 32'(pass[1]), 1);

      // abort on the third run cycle while START stays high
      mode[0] = 0;
      start[0] = 1'b1;
      repeat (3) cyc();
      abort[0] = 1'b1;
      cyc();
      check("abort_pat", 32'(pat[0]), 32'h1);
      check("abort_sig", 32'(sig[0]), 0);
      check("abort_busy", 32'(busy[0]), 0);
      check("abort_done", 32'(done[0]), 0);
      abort[0] = 1'b0;
      start[0] = 1'b0;
      repeat (3) cyc();

      // asynchronous reset mid-run, then back-to-back sessions with START held
      mode[0] = 1;
      start[0] = 1'b1;
      repeat (5) cyc();
      #2;
      RN = 1'b0;
      #1;
      check_reset_vals("async_rst");
      RN = 1'b1;
      done_q.delete();
      rec_done = 1'b1;
      repeat (45) cyc();
      rec_done = 1'b0;
      start[0] = 1'b0;
      check("b2b_done_cycles", done_q.size(), 2);
      if (done_q.size() >= 2) check("b2b_same_sig", 32'(done_q[1]), 32'(done_q[0]));
      repeat (3) cyc();

      // randomized traffic on both instances
      for (int n = 0; n < 700; n++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(31) == 0) mode[i] = int'($urandom_range(2));
            start[i]  = ($urandom_range(5) == 0);
            abort[i]  = ($urandom_range(63) == 0);
            golden[i] = (mode[i] == 2) ? 4'h0 : W'($urandom);
         end
         cyc();
      end
      start = 2'b00; abort = 2'b00;
      repeat (3) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
